reg_bank_writer: RTL and testbench
==================================

Name: reg_bank_writer

Overview:
- Write side of the 8 x 32-bit register bank; the bank's read side is the existing 8:1 32-bit mux tree.
- Accepts byte-masked write requests over a valid/ready handshake into a one-entry pending stage.
- Decodes the 3-bit address one-hot and commits the pending write to the addressed register.
- Exposes all eight registers as a flat bus for the read muxes.

Parameters:
- WIDTH, 32, register data width in bits (must be a multiple of 8).
- NREGS, 8, number of registers (fixed at 8; address width 3).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- WValid  input  1  write request valid.
- WReady  output  1  block can accept a request this cycle.
- WAddr  input  3  target register index.
- WData  input  WIDTH  write data.
- WMask  input  WIDTH/8  byte enables; bit b covers data bits [8b+7:8b].
- Hold  input  1  freezes commit; the pending entry is retained.
- Regs  output  NREGS*WIDTH  register contents; register i at bits [WIDTH*i +: WIDTH].
- PendValid  output  1  pending stage is occupied.
- CommitCnt  output  8  number of commits, wraps modulo 256.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - All registers 0.
  - PendValid 0, pending addr/data/mask 0.
  - CommitCnt 0.
  - WReady forced 0 while reset is high.
- Handshake:
  - WReady = !reset && (!PendValid || !Hold), combinational.
  - A request is accepted on an edge where WValid && WReady.
  - WAddr/WData/WMask must be stable while WValid is high and WReady is low.
  - WValid may drop without acceptance; nothing is captured.
- Commit:
  - Fires on an edge where PendValid && !Hold.
  - For each byte b with mask bit set, Regs[PendAddr] byte b takes PendData byte b; unmasked bytes keep their old value.
  - CommitCnt increments, 255 -> 0.
- Pending stage update per edge, priority in this order:
  - reset: clear.
  - accept: load the new request, PendValid=1 (covers accept-with-commit and accept-into-empty).
  - commit without accept: PendValid=0.
  - otherwise: hold.
- Latency:
  - Accepted at edge k; committed at the first edge j>k with Hold low in cycle j.
  - New value is visible on Regs immediately after edge j.
  - With Hold low, throughput is 1 write/cycle.
- Ordering:
  - Commits occur in acceptance order.
  - Back-to-back writes to the same address: the later one wins, one cycle after the earlier.
- WMask=0: accepted and committed normally, no register change, CommitCnt still increments.
- Hold: high with PendValid=1 deasserts WReady; the pending entry is kept unchanged, with no loss or duplication.
- Reset mid-operation: the pending write is discarded and not committed; registers clear even if a commit would fire that edge.
- Regs is driven directly from flops; no combinational path from inputs to Regs.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN.
- When defined:
  - Register 0 is hardwired to 0 and Regs[WIDTH-1:0] is always 0.
  - Requests to address 0 are accepted and committed normally, and CommitCnt increments, but data is discarded.
- When undefined: register 0 is an ordinary writable register.

Decomposition:
- Package reg_bank_pkg:
  - Constants REG_WIDTH=32, REG_COUNT=8, REG_ADDR_W=3, REG_MASK_W=4.
  - typedefs reg_word_t logic[31:0], reg_addr_t logic[2:0], reg_mask_t logic[3:0].
- Sub-module dec3to8: combinational 3-to-8 one-hot decoder with enable.
  - Output bit i = En && (A==i).
  - Drives per-register write strobes, the inverse of the read-side mux tree.

Test Plan:
- Reset: assert reset 2 cycles -> Regs all 0, PendValid=0, CommitCnt=0, WReady=0 during reset and 1 the cycle after.
- Single write: WAddr=5, WData=32'hDEADBEEF, WMask=4'hF, Hold=0 -> register 5 = DEADBEEF after the second edge, CommitCnt=1, other registers 0.
- Byte mask: register 2 = 32'h11223344, then write 32'hAABBCCDD with WMask=4'b0101 -> register 2 = 32'h11BB33DD.
- Back-to-back same address: addr 3 data 1 then data 2 on consecutive cycles, Hold=0 -> WReady stays 1, register 3 = 1 then 2, CommitCnt=+2.
- Hold stall plus reset mid-op: accept addr 7 data 32'h55, Hold=1 for 4 cycles -> WReady=0 and register 7 unchanged; release Hold -> register 7 = 32'h55. Repeat, then assert reset while pending -> register 7 = 0 and no commit.
- Counter wrap plus zero register: 256 writes -> CommitCnt=0. With REG_BANK_ZERO_REG_EN, write 32'hFFFFFFFF to addr 0 -> register 0 reads 0 and CommitCnt increments.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared sizes and types for the 8 x 32-bit register bank.
package reg_bank_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_COUNT  = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_MASK_W = 4;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_MASK_W-1:0] reg_mask_t;

endpackage

// File: rtl/reg_bank_writer_dec3to8.sv
// 3-to-8 one-hot decoder with enable; produces per-register write strobes.
module dec3to8
  import reg_bank_pkg::*;
(
  input  logic                 en,
  input  reg_addr_t            a,
  output logic [REG_COUNT-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the register bank: one-entry pending stage, byte-masked commit.
// Optional REG_BANK_ZERO_REG_EN makes register 0 read as constant zero.
module reg_bank_writer
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH,
  parameter int unsigned NREGS = REG_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   WValid,
  output logic                   WReady,
  input  logic [2:0]             WAddr,
  input  logic [WIDTH-1:0]       WData,
  input  logic [WIDTH/8-1:0]     WMask,
  input  logic                   Hold,
  output logic [NREGS*WIDTH-1:0] Regs,
  output logic                   PendValid,
  output logic [7:0]             CommitCnt
);

  localparam int unsigned MASK_W = WIDTH / 8;

`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  logic                 pend_valid_q;
  reg_addr_t            pend_addr_q;
  logic [WIDTH-1:0]     pend_data_q;
  logic [MASK_W-1:0]    pend_mask_q;
  logic [7:0]           cnt_q;
  logic [WIDTH-1:0]     regs_q [NREGS];

  logic                 accept;
  logic                 commit;
  logic [WIDTH-1:0]     wbits;
  logic [REG_COUNT-1:0] strobe;

  assign WReady = !reset && (!pend_valid_q || !Hold);
  assign accept = WValid && WReady;
  assign commit = pend_valid_q && !Hold;

  // Expand the byte mask to a per-bit write mask.
  always_comb begin
    wbits = '0;
    for (int b = 0; b < int'(MASK_W); b++) begin
      wbits[8*b +: 8] = {8{pend_mask_q[b]}};
    end
  end

  dec3to8 u_dec (
    .en (commit),
    .a  (pend_addr_q),
    .y  (strobe)
  );

  // Pending stage: accept takes priority over the commit that empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= WAddr;
      pend_data_q  <= WData;
      pend_mask_q  <= WMask;
    end else if (commit) begin
      pend_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= 8'(cnt_q + 8'd1);
    end
  end

  // Register array; reset wins over a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (strobe[i] && !(ZERO_REG_EN && i == 0)) begin
          regs_q[i] <= (regs_q[i] & ~wbits) | (pend_data_q & wbits);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_flat
    if (ZERO_REG_EN && g == 0) begin : g_zero
      assign Regs[WIDTH*g +: WIDTH] = '0;
    end else begin : g_reg
      assign Regs[WIDTH*g +: WIDTH] = regs_q[g];
    end
  end

  assign PendValid = pend_valid_q;
  assign CommitCnt = cnt_q;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: directed table, corner sequences, random vs model.
module tb_reg_bank_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         WValid;
  logic         WReady;
  logic [2:0]   WAddr;
  logic [31:0]  WData;
  logic [3:0]   WMask;
  logic         Hold;
  logic [255:0] Regs;
  logic         PendValid;
  logic [7:0]   CommitCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_writer dut (
    .clk       (clk),
    .reset     (reset),
    .WValid    (WValid),
    .WReady    (WReady),
    .WAddr     (WAddr),
    .WData     (WData),
    .WMask     (WMask),
    .Hold      (Hold),
    .Regs      (Regs),
    .PendValid (PendValid),
    .CommitCnt (CommitCnt)
  );

  // Behavioural model: FIFO of accepted requests, each retired on a non-held edge.
  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } req_t;

  req_t        mq[$];
  logic [31:0] mregs[8];
  int          mcnt = 0;
  logic        m_rdy;

`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct packed {
    logic        r, v;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        h;
    logic        erdy, epv;
    logic [7:0]  ecnt;
    logic [2:0]  ca;
    logic [31:0] ereg;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [2:0] a, logic [31:0] d, logic [3:0] m,
                              logic h, logic erdy, logic epv, logic [7:0] ecnt,
                              logic [2:0] ca, logic [31:0] ereg);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.d = d; t.m = m; t.h = h;
    t.erdy = erdy; t.epv = epv; t.ecnt = ecnt; t.ca = ca; t.ereg = ereg;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input logic [2:0] i);
    logic [255:0] r;
    r = Regs;
    return r[32*i +: 32];
  endfunction

  // One clock: drive at negedge, sample WReady before the edge, advance model, settle after edge.
  task automatic step(input logic r, input logic v, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic h, output logic rdy, output logic acc);
    req_t c;
    @(negedge clk);
    reset = r; WValid = v; WAddr = a; WData = d; WMask = m; Hold = h;
    #1;
    rdy   = WReady;
    m_rdy = !r && !(mq.size() != 0 && h);
    acc   = v && m_rdy;
    if (r) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      mcnt = 0;
    end else begin
      if (mq.size() != 0 && !h) begin
        c = mq.pop_front();
        for (int b = 0; b < 4; b++) begin
          if (c.m[b] && !(ZERO_EN && c.a == 3'd0)) mregs[c.a][8*b +: 8] = c.d[8*b +: 8];
        end
        mcnt = (mcnt + 1) % 256;
      end
      if (acc) begin
        c.a = a; c.d = d; c.m = m;
        mq.push_back(c);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[20];
  logic rdy, acc;

  initial begin
    int rdy_drops;
    logic stuck;
    logic r, v, h;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  m;

    reset = 1'b1; WValid = 1'b0; WAddr = '0; WData = '0; WMask = '0; Hold = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;

    //          r  v  a     data          mask  h  rdy pv  cnt   chk  reg
    vt[0]  = mk(1, 0, 3'd0, 32'h0,        4'h0, 0, 0,  0,  8'd0, 3'd5, 32'h0);
    vt[1]  = mk(1, 0, 3'd0, 32'h0,        4'h0, 0, 0,  0,  8'd0, 3'd3, 32'h0);
    vt[2]  = mk(0, 1, 3'd5, 32'hDEADBEEF, 4'hF, 0, 1,  1,  8'd0, 3'd5, 32'h0);
    vt[3]  = mk(0, 0, 3'd0, 32'h0,        4'h0, 0, 1,  0,  8'd1, 3'd5, 32'hDEADBEEF);
    vt[4]  = mk(0, 1, 3'd2, 32'h11223344, 4'hF, 0, 1,  1,  8'd1, 3'd4, 32'h0);
    vt[5]  = mk(0, 1, 3'd2, 32'hAABBCCDD, 4'h5, 0, 1,  1,  8'd2, 3'd2, 32'h11223344);
    vt[6]  = mk(0, 0, 3'd0, 32'h0,        4'h0, 0, 1,  0,  8'd3, 3'd2, 32'h11BB33DD);
    vt[7]  = mk(0, 1, 3'd3, 32'h1,        4'hF, 0, 1,  1,  8'd3, 3'd3, 32'h0);
    vt[8]  = mk(0, 1, 3'd3, 32'h2,        4'hF, 0, 1,  1,  8'd4, 3'd3, 32'h1);
    vt[9]  = mk(0, 0, 3'd0, 32'h0,        4'h0, 0, 1,  0,  8'd5, 3'd3, 32'h2);
    vt[10] = mk(0, 1, 3'd7, 32'h55,       4'hF, 0, 1,  1,  8'd5, 3'd7, 32'h0);
    vt[11] = mk(0, 0, 3'd0, 32'h0,        4'h0, 1, 0,  1,  8'd5, 3'd7, 32'h0);
    vt[12] = mk(0, 0, 3'd0, 32'h0,        4'h0, 1, 0,  1,  8'd5, 3'd7, 32'h0);
    vt[13] = mk(0, 0, 3'd0, 32'h0,        4'h0, 1, 0,  1,  8'd5, 3'd7, 32'h0);
    vt[14] = mk(0, 0, 3'd0, 32'h0,        4'h0, 1, 0,  1,  8'd5, 3'd7, 32'h0);
    vt[15] = mk(0, 0, 3'd0, 32'h0,        4'h0, 0, 1,  0,  8'd6, 3'd7, 32'h55);
    vt[16] = mk(0, 1, 3'd7, 32'h66,       4'hF, 1, 1,  1,  8'd6, 3'd7, 32'h55);
    vt[17] = mk(0, 0, 3'd0, 32'h0,        4'h0, 1, 0,  1,  8'd6, 3'd7, 32'h55);
    vt[18] = mk(1, 0, 3'd0, 32'h0,        4'h0, 0, 0,  0,  8'd0, 3'd7, 32'h0);
    vt[19] = mk(0, 0, 3'd0, 32'h0,        4'h0, 0, 1,  0,  8'd0, 3'd5, 32'h0);

    for (int i = 0; i < 20; i++) begin
      step(vt[i].r, vt[i].v, vt[i].a, vt[i].d, vt[i].m, vt[i].h, rdy, acc);
      chk($sformatf("vec%0d.wready", i), 32'(rdy),       32'(vt[i].erdy));
      chk($sformatf("vec%0d.pend",   i), 32'(PendValid), 32'(vt[i].epv));
      chk($sformatf("vec%0d.cnt",    i), 32'(CommitCnt), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d.reg",    i), reg_of(vt[i].ca), vt[i].ereg);
    end

    // 256 back-to-back commits wrap the counter to zero; WReady never drops.
    rdy_drops = 0;
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b1, 3'd1, 32'(k), 4'hF, 1'b0, rdy, acc);
      if (!rdy) rdy_drops++;
    end
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, rdy, acc);
    chk("wrap.rdy_drops", 32'(rdy_drops), 32'd0);
    chk("wrap.cnt",       32'(CommitCnt), 32'd0);
    chk("wrap.pend",      32'(PendValid), 32'd0);
    chk("wrap.reg1",      reg_of(3'd1),   32'd255);

    // Masked-off write still commits and counts.
    step(1'b0, 1'b1, 3'd1, 32'hFFFFFFFF, 4'h0, 1'b0, rdy, acc);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, rdy, acc);
    chk("mask0.cnt",  32'(CommitCnt), 32'd1);
    chk("mask0.reg1", reg_of(3'd1),   32'd255);

    // Write to address 0: ordinary register, or discarded when hardwired.
    step(1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0, rdy, acc);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, rdy, acc);
    chk("zero.cnt",  32'(CommitCnt), 32'd2);
    chk("zero.reg0", reg_of(3'd0),   ZERO_EN ? 32'h0 : 32'hFFFFFFFF);

    // Random traffic against the model; a stalled request is held stable until taken.
    stuck = 1'b0;
    v = 1'b0; a = '0; d = '0; m = '0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 149) == 0);
      h = ($urandom_range(0, 99) < 30);
      if (!stuck) begin
        v = ($urandom_range(0, 3) != 0);
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        m = 4'($urandom_range(0, 15));
      end
      step(r, v, a, d, m, h, rdy, acc);
      stuck = v && !acc && !r;
      chk("rnd.wready", 32'(rdy),       32'(m_rdy));
      chk("rnd.pend",   32'(PendValid), 32'(mq.size() != 0));
      chk("rnd.cnt",    32'(CommitCnt), 32'(mcnt));
      for (int i = 0; i < 8; i++) chk($sformatf("rnd.reg%0d", i), reg_of(3'(i)), mregs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
